mod5_rr_sched: RTL and testbench

Round-robin scheduler that shares one resource among five requesters using a mod-5 priority pointer (0→1→2→3→4→0). It sits between the requester ports and the shared resource. It issues at most one registered one-hot grant at a time, holds the grant until the owner finishes, then advances priority past the winner.

---
 rtl/mod5_sched_pkg.sv | 24 ++
 rtl/mod5_ptr.sv | 21 ++
 rtl/mod5_rr_sched.sv | 119 +++++++++++
 tb/tb_mod5_rr_sched.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mod5_sched_pkg.sv
// Shared types and helpers for the mod-5 round-robin scheduler.
package mod5_sched_pkg;

    localparam int NREQ   = 5;
    localparam int SLOT_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Successor of a mod-5 pointer; out-of-range values collapse to 0.
    function automatic logic [SLOT_W-1:0] mod5_inc(input logic [SLOT_W-1:0] v);
        case (v)
            3'd0:    mod5_inc = 3'd1;
            3'd1:    mod5_inc = 3'd2;
            3'd2:    mod5_inc = 3'd3;
            3'd3:    mod5_inc = 3'd4;
            default: mod5_inc = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mod5_ptr.sv
// Mod-5 priority pointer: loads winner+1 (mod 5) on grant, scrubs illegal codes to 0.
module mod5_ptr
    import mod5_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [SLOT_W-1:0] winner,
    output logic [SLOT_W-1:0] slot
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            slot <= '0;
        else if (load)
            slot <= mod5_inc(winner);
        else if (slot > 3'd4)
            slot <= '0;
    end

endmodule

// File: rtl/mod5_rr_sched.sv
// Five-way round-robin scheduler with held one-hot grant.
// Optional forced release after HOLD_MAX grant cycles via MOD5_RR_SCHED_TIMEOUT_EN.
module mod5_rr_sched
    import mod5_sched_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   gnt,
    output logic [SLOT_W-1:0] slot,
    output logic              busy,
    output logic              timeout
);

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
        $error("mod5_rr_sched: HOLD_MAX must be 1..255");
    end

    state_t            state;
    logic [SLOT_W-1:0] win;
    logic [SLOT_W-1:0] start;
    logic [SLOT_W-1:0] scan_w;
    logic              scan_hit;
    logic [3:0]        idx;
    logic              load;
    logic              rel;
    logic              limit;

    // Scan from the pointer, wrapping mod 5; first set request wins.
    always_comb begin
        start    = (slot > 3'd4) ? '0 : slot;
        scan_hit = 1'b0;
        scan_w   = '0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, start} + 4'(k);
            if (idx >= 4'd5)
                idx = idx - 4'd5;
            if (!scan_hit && req[idx[2:0]]) begin
                scan_hit = 1'b1;
                scan_w   = idx[2:0];
            end
        end
    end

    assign load = (state == IDLE) && scan_hit;
    assign rel  = done[win] || !req[win];

    mod5_ptr u_ptr (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .winner (scan_w),
        .slot   (slot)
    );

`ifdef MOD5_RR_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    logic [CNT_W-1:0] hold;
    logic [CNT_W-1:0] hold_nxt;

    // hold_nxt counts the current GRANT cycle, so gnt stays up exactly HOLD_MAX cycles.
    assign hold_nxt = hold + CNT_W'(1);
    assign limit    = (hold_nxt == CNT_W'(HOLD_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hold <= '0;
        else if (load)
            hold <= '0;
        else if (state == GRANT)
            hold <= hold_nxt;
    end
`else
    assign limit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            win     <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan_hit) begin
                        gnt   <= NREQ'(1) << scan_w;
                        busy  <= 1'b1;
                        win   <= scan_w;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    // done/req-drop outranks the hold limit
                    if (rel || limit) begin
                        gnt     <= '0;
                        busy    <= 1'b0;
                        timeout <= !rel;
                        state   <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod5_rr_sched.sv
// Directed self-checking bench for mod5_rr_sched (HOLD_MAX=4).
module tb_mod5_rr_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req;
    logic [4:0] done;
    logic [4:0] gnt;
    logic [2:0] slot;
    logic       busy;
    logic       timeout;

    int n_chk  = 0;
    int n_pass = 0;

    mod5_rr_sched #(.HOLD_MAX(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .slot    (slot),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    // expected winners / slots for req=11111 starting at slot 0
    int exp_w[6]    = '{0, 1, 2, 3, 4, 0};
    int exp_slot[6] = '{1, 2, 3, 4, 0, 1};

    initial begin
        rst  = 1'b1;
        req  = '0;
        done = '0;
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_slot", 32'(slot), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_to", 32'(timeout), 0);
        cyc();
        rst = 1'b0;

        // single requester, done release, dead cycle, re-grant
        req = 5'b00001;
        cyc();
        chk("t1_gnt", 32'(gnt), 32'h01);
        chk("t1_slot", 32'(slot), 1);
        chk("t1_busy", 32'(busy), 1);
        done = 5'b00001;
        cyc();
        chk("t1_rel_gnt", 32'(gnt), 0);
        chk("t1_rel_busy", 32'(busy), 0);
        done = '0;
        cyc();
        chk("t1_dead", 32'(gnt), 0);
        cyc();
        chk("t1_regnt", 32'(gnt), 32'h01);
        done = 5'b00001;
        cyc();
        done = '0;
        req  = '0;
        cyc();
        cyc();

        // all requesting: rotate 0..4,0
        do_reset();
        req = 5'b11111;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("rr_gnt", 32'(gnt), 32'(1) << exp_w[i]);
            chk("rr_slot", 32'(slot), 32'(exp_slot[i]));
            chk("rr_onehot", 32'($onehot(gnt)), 1);
            chk("rr_busy", 32'(busy), 1);
            done = 5'b11111;
            cyc();
            chk("rr_rel", 32'(gnt), 0);
            done = '0;
            cyc();
            chk("rr_dead", 32'(gnt), 0);
        end
        req = '0;
        cyc();

        // slot=1: grant 2, wrong-bit done ignored, req drop releases
        req = 5'b00100;
        cyc();
        chk("t4_gnt", 32'(gnt), 32'h04);
        chk("t4_slot", 32'(slot), 3);
        done = 5'b00010;
        cyc();
        chk("t4_wrongdone", 32'(gnt), 32'h04);
        done = '0;
        req  = '0;
        cyc();
        chk("t4_drop", 32'(gnt), 0);
        // slot=3, req=00101 -> scan 3,4,0 -> winner 0
        req = 5'b00101;
        cyc();
        chk("t3_dead", 32'(gnt), 0);
        cyc();
        chk("t3_gnt", 32'(gnt), 32'h01);
        chk("t3_slot", 32'(slot), 1);
        req = 5'b00111;
        cyc();
        chk("t3_other_req", 32'(gnt), 32'h01);
        done = 5'b00001;
        cyc();
        chk("t3_rel", 32'(gnt), 0);
        done = '0;
        req  = '0;
        cyc();
        cyc();

        // slot=1, req=01000 -> winner 3, slot 4
        req = 5'b01000;
        cyc();
        chk("hold_gnt", 32'(gnt), 32'h08);
        chk("hold_slot", 32'(slot), 4);
`ifdef MOD5_RR_SCHED_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("to_held", 32'(gnt), 32'h08);
            chk("to_low", 32'(timeout), 0);
        end
        cyc();
        chk("to_rel", 32'(gnt), 0);
        chk("to_pulse", 32'(timeout), 1);
        cyc();
        chk("to_pulse_end", 32'(timeout), 0);
        cyc();
        chk("to_regnt", 32'(gnt), 32'h08);
        cyc();
        cyc();
        cyc();
        done = 5'b01000;
        cyc();
        chk("to_done_rel", 32'(gnt), 0);
        chk("to_done_wins", 32'(timeout), 0);
`else
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("noto_held", 32'(gnt), 32'h08);
            chk("noto_to", 32'(timeout), 0);
        end
        done = 5'b01000;
        cyc();
        chk("noto_rel", 32'(gnt), 0);
`endif
        done = '0;
        req  = '0;
        cyc();
        cyc();

        // async reset mid-grant; slot=4 -> scan 4,0,1,2,3 -> winner 3
        req = 5'b01000;
        cyc();
        chk("ar_gnt", 32'(gnt), 32'h08);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_gnt0", 32'(gnt), 0);
        chk("ar_busy0", 32'(busy), 0);
        chk("ar_slot0", 32'(slot), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 5'b01010;
        cyc();
        chk("ar_scan0", 32'(gnt), 32'h02);
        chk("ar_slot", 32'(slot), 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
